seq_signed_divider: RTL and testbench

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

---
 rtl/div_pkg.sv | 25 ++
 rtl/sign_magn.sv | 16 +
 rtl/seq_signed_divider.sv | 155 +++++++++++++++
 tb/tb_seq_signed_divider.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// iteration-counter sizing and the fixed results returned for exceptional operands.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Exception results: divide-by-zero gives an all-ones quotient, both exceptions a zero
  // remainder, and overflow the most-negative quotient (sign bit set, rest clear).
  localparam logic DZ_QUOT_FILL = 1'b1;
  localparam logic EXC_REM_FILL = 1'b0;
  localparam logic OVF_QUOT_MSB = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sign_magn.sv
// Two's-complement to magnitude/sign converter; force_neg turns it into a plain
// negator for values that are already magnitudes.
module sign_magn #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             force_neg,
  output logic [WIDTH-1:0] magn,
  output logic             sign
);

  // 2^(WIDTH-1) is its own negation, so the most-negative input yields its unsigned magnitude.
  assign sign = value[WIDTH-1];
  assign magn = (sign | force_neg) ? -value : value;

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring radix-2 core on operand magnitudes, one quotient
// bit per cycle, with signs and exception results applied in a single FIX cycle.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [W-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] quot,
  output logic [W-1:0] rem,
  output logic         dz,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CNT_W = clog2(N + 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       pr;
  logic [N-1:0]     q;
  logic [W-1:0]     b_mag;
  logic             a_sign;
  logic             b_sign;
  logic             dz_pend;
  logic             ovf_pend;

  logic [N-1:0]     a_mag_in;
  logic [W-1:0]     b_mag_in;
  logic             a_sign_in;
  logic             b_sign_in;
  logic [N+1:0]     diff;
  logic [N-1:0]     q_signed;
  logic [W-1:0]     r_signed;
  logic             q_sign_unused;
  logic             r_sign_unused;

  sign_magn #(.WIDTH(N)) u_mag_a (
    .value     (a),
    .force_neg (1'b0),
    .magn      (a_mag_in),
    .sign      (a_sign_in)
  );

  sign_magn #(.WIDTH(W)) u_mag_b (
    .value     (b),
    .force_neg (1'b0),
    .magn      (b_mag_in),
    .sign      (b_sign_in)
  );

  // In FIX the quotient magnitude is at most 2^(N-1) and the remainder magnitude below
  // 2^(W-1), so their own sign bits never cause an unwanted negation.
  sign_magn #(.WIDTH(N)) u_neg_q (
    .value     (q),
    .force_neg (a_sign ^ b_sign),
    .magn      (q_signed),
    .sign      (q_sign_unused)
  );

  sign_magn #(.WIDTH(W)) u_neg_r (
    .value     (pr[W-1:0]),
    .force_neg (a_sign),
    .magn      (r_signed),
    .sign      (r_sign_unused)
  );

  // Trial subtraction of the shifted partial remainder; the top bit is the borrow.
  assign diff = {pr, q[N-1]} - {{(N + 2 - W){1'b0}}, b_mag};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      pr        <= '0;
      q         <= '0;
      b_mag     <= '0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
      dz_pend   <= 1'b0;
      ovf_pend  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CALC;
            in_ready <= 1'b0;
            cnt      <= CNT_W'(N);
            pr       <= '0;
            q        <= a_mag_in;
            b_mag    <= b_mag_in;
            a_sign   <= a_sign_in;
            b_sign   <= b_sign_in;
            dz_pend  <= (b_mag_in == '0);
            ovf_pend <= a_mag_in[N-1] && b_sign_in && (b_mag_in == W'(1));
          end
        end
        // The dividend shifts out of q's top while quotient bits shift in at the bottom;
        // the extra cycle seeing cnt == 0 makes the result land N+2 cycles after accept.
        CALC: begin
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (diff[N+1]) begin
              pr <= {pr[N-1:0], q[N-1]};
              q  <= {q[N-2:0], 1'b0};
            end else begin
              pr <= diff[N:0];
              q  <= {q[N-2:0], 1'b1};
            end
          end
        end
        FIX: begin
          state     <= DONE;
          out_valid <= 1'b1;
          dz        <= dz_pend;
          ovf       <= ovf_pend;
          if (dz_pend) begin
            quot <= {N{DZ_QUOT_FILL}};
            rem  <= {W{EXC_REM_FILL}};
          end else if (ovf_pend) begin
            quot <= {OVF_QUOT_MSB, {(N - 1){~OVF_QUOT_MSB}}};
            rem  <= {W{EXC_REM_FILL}};
          end else begin
            quot <= q_signed;
            rem  <= r_signed;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed table, random traffic against a
// truncating-division model, backpressure, reset abort and an exhaustive N=6/W=4 sweep.
module tb_seq_signed_divider;

  logic clk;
  logic rst;

  logic [15:0] a16;
  logic [4:0]  b16;
  logic        iv16, ir16, ov16, or16, dz16, ovf16;
  logic [15:0] q16;
  logic [4:0]  r16;

  logic [5:0]  a6;
  logic [3:0]  b6;
  logic        iv6, ir6, ov6, or6, dz6, ovf6;
  logic [5:0]  q6;
  logic [3:0]  r6;

  seq_signed_divider #(.N(16), .W(5)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .in_valid(iv16), .in_ready(ir16),
    .quot(q16), .rem(r16), .dz(dz16), .ovf(ovf16), .out_valid(ov16), .out_ready(or16)
  );

  seq_signed_divider #(.N(6), .W(4)) dut6 (
    .clk(clk), .rst(rst), .a(a6), .b(b6), .in_valid(iv6), .in_ready(ir6),
    .quot(q6), .rem(r6), .dz(dz6), .ovf(ovf6), .out_valid(ov6), .out_ready(or6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int quot;
    int rem;
    bit dz;
    bit ovf;
  } res_t;

  typedef struct {
    int a;
    int b;
    int quot;
    int rem;
    bit dz;
    bit ovf;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  bit   use6;
  logic cur_ov, cur_ir, cur_dz, cur_ovf;
  int   cur_q, cur_r;

  always_comb begin
    if (use6) begin
      cur_ov  = ov6;
      cur_ir  = ir6;
      cur_dz  = dz6;
      cur_ovf = ovf6;
      cur_q   = int'(q6);
      cur_r   = int'(r6);
    end else begin
      cur_ov  = ov16;
      cur_ir  = ir16;
      cur_dz  = dz16;
      cur_ovf = ovf16;
      cur_q   = int'(q16);
      cur_r   = int'(r16);
    end
  end

  function automatic int mask(input int v, input int w);
    return v & ((1 << w) - 1);
  endfunction

  // Truncating division with the divide-by-zero and most-negative/-1 exception rules.
  function automatic res_t ref_div(input int av, input int bv, input int nw);
    res_t r;
    r = '{0, 0, 1'b0, 1'b0};
    if (bv == 0) begin
      r.dz   = 1'b1;
      r.quot = -1;
    end else if (av == -(1 << (nw - 1)) && bv == -1) begin
      r.ovf  = 1'b1;
      r.quot = av;
    end else begin
      r.quot = av / bv;
      r.rem  = av % bv;
    end
    return r;
  endfunction

  function automatic int pack(input logic ir, input logic ov, input logic dzf,
                              input logic ovff, input int r, input int q);
    return (int'(ir) << 24) | (int'(ov) << 23) | (int'(dzf) << 22) | (int'(ovff) << 21)
         | ((r & 32'h1F) << 16) | (q & 32'hFFFF);
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int av, input int bv);
    @(negedge clk);
    if (use6) begin
      a6  = 6'(av);
      b6  = 4'(bv);
      iv6 = 1'b1;
    end else begin
      a16  = 16'(av);
      b16  = 5'(bv);
      iv16 = 1'b1;
    end
    check_output("in_ready before accept", int'(cur_ir), 1);
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    iv6  = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!cur_ov && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    or16 = 1'b1;
    or6  = 1'b1;
    @(posedge clk);
    #1;
    or16 = 1'b0;
    or6  = 1'b0;
  endtask

  task automatic run_op(input string name, input int av, input int bv, input res_t e,
                        input int nw, input int ww);
    int lat;
    apply_stimulus(av, bv);
    wait_result(lat);
    check_output({name, " latency"}, lat, nw + 2);
    check_output({name, " result"},
                 pack(cur_ir, cur_ov, cur_dz, cur_ovf, cur_r, cur_q),
                 pack(1'b0, 1'b1, e.dz, e.ovf, mask(e.rem, ww), mask(e.quot, nw)));
    release_result();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    res_t e;
    int   lat;
    int   av, bv;
    bit   seen;

    rst = 1'b1;
    use6 = 1'b0;
    a16 = '0; b16 = '0; iv16 = 1'b0; or16 = 1'b0;
    a6 = '0; b6 = '0; iv6 = 1'b0; or6 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset in_ready", int'(ir16), 1);
    check_output("reset out_valid", int'(ov16), 0);
    check_output("reset quot", int'(q16), 0);
    check_output("reset rem", int'(r16), 0);
    check_output("reset dz", int'(dz16), 0);
    check_output("reset ovf", int'(ovf16), 0);
    @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{7, 2, 3, 1, 1'b0, 1'b0};
    tbl[1] = '{-7, 2, -3, -1, 1'b0, 1'b0};
    tbl[2] = '{7, -2, -3, 1, 1'b0, 1'b0};
    tbl[3] = '{-7, -2, 3, -1, 1'b0, 1'b0};
    tbl[4] = '{-32768, -1, -32768, 0, 1'b0, 1'b1};
    tbl[5] = '{1234, 0, -1, 0, 1'b1, 1'b0};
    tbl[6] = '{100, -7, -14, 2, 1'b0, 1'b0};
    tbl[7] = '{32767, 15, 2184, 7, 1'b0, 1'b0};
    tbl[8] = '{-32768, -16, 2048, 0, 1'b0, 1'b0};
    foreach (tbl[i]) begin
      e = '{tbl[i].quot, tbl[i].rem, tbl[i].dz, tbl[i].ovf};
      run_op($sformatf("table[%0d]", i), tbl[i].a, tbl[i].b, e, 16, 5);
    end

    for (int i = 0; i < 150; i++) begin
      av = int'($urandom_range(65535, 0)) - 32768;
      bv = int'($urandom_range(31, 0)) - 16;
      run_op($sformatf("random a=%0d b=%0d", av, bv), av, bv, ref_div(av, bv, 16), 16, 5);
    end

    // Backpressure: result must hold and new operands must be ignored until consumed.
    apply_stimulus(1000, 3);
    wait_result(lat);
    check_output("backpressure latency", lat, 18);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv16 = i[0];
      a16  = 16'(i * 111);
      b16  = 5'd1;
      @(posedge clk);
      #1;
      check_output($sformatf("backpressure hold %0d", i),
                   pack(cur_ir, cur_ov, cur_dz, cur_ovf, cur_r, cur_q),
                   pack(1'b0, 1'b1, 1'b0, 1'b0, 1, 333));
    end
    @(negedge clk);
    iv16 = 1'b1;
    a16  = 16'd77;
    b16  = 5'd5;
    or16 = 1'b1;
    @(posedge clk);
    #1;
    check_output("consume in_ready", int'(cur_ir), 1);
    check_output("consume out_valid", int'(cur_ov), 0);
    @(negedge clk);
    iv16 = 1'b0;
    or16 = 1'b0;
    @(posedge clk);
    #1;
    check_output("no accept on consume edge", int'(cur_ir), 1);

    // Reset in the fifth CALC cycle must abort the division silently.
    apply_stimulus(500, 3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort in_ready", int'(cur_ir), 1);
    check_output("abort out_valid", int'(cur_ov), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (cur_ov) seen = 1'b1;
    end
    check_output("abort no result", int'(seen), 0);
    e = '{-14, 2, 1'b0, 1'b0};
    run_op("after abort", 100, -7, e, 16, 5);

    use6 = 1'b1;
    for (int ai = -32; ai < 32; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        run_op($sformatf("exhaustive a=%0d b=%0d", ai, bi), ai, bi, ref_div(ai, bi, 6), 6, 4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
